// File: rtl/rf_arb_pkg.sv
// Shared types for the register-file write-port arbiter: FIFO entry layout,
// grant source and the hardwired-zero register index.
package rf_arb_pkg;
  localparam int RF_XLEN = 32;
  localparam int RF_AW   = 5;

  localparam logic [RF_AW-1:0] ZERO_REG = '0;

  typedef struct packed {
    logic               valid;
    logic               kill;
    logic [RF_AW-1:0]   rd;
    logic [RF_XLEN-1:0] data;
  } rf_entry_t;

  typedef enum logic [1:0] {GNT_NONE, GNT_WB, GNT_MDU} gnt_src_t;
endpackage

// File: rtl/rf_arb_fifo.sv
// Buffer for mdu results waiting for the write port. A kill strobe marks every
// queued entry with a matching rd as superseded by a younger writeback.
module rf_arb_fifo
  import rf_arb_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic [RF_AW-1:0]              push_rd,
  input  logic [RF_XLEN-1:0]            push_data,
  input  logic                          pop,
  input  logic                          kill_en,
  input  logic [RF_AW-1:0]              kill_rd,
  output rf_entry_t                     head,
  output logic [DEPTH-1:0]              ent_valid,
  output logic [DEPTH-1:0]              ent_kill,
  output logic [DEPTH-1:0][RF_AW-1:0]   ent_rd,
  output logic [PW:0]                   count,
  output logic                          full,
  output logic                          empty
);
  rf_entry_t       mem [DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic            do_pop;

  assign do_pop = pop && !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (kill_en && mem[i].valid && mem[i].rd == kill_rd) mem[i].kill <= 1'b1;
      end
      if (do_pop) begin
        mem[rd_ptr].valid <= 1'b0;
        rd_ptr <= rd_ptr + PW'(1);
      end
      // The tail slot is never valid when push is allowed, so a same-edge kill cannot hit it.
      if (push) begin
        mem[wr_ptr] <= '{valid: 1'b1, kill: 1'b0, rd: push_rd, data: push_data};
        wr_ptr <= wr_ptr + PW'(1);
      end
      case ({push, do_pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_valid[i] = mem[i].valid;
      ent_kill[i]  = mem[i].kill;
      ent_rd[i]    = mem[i].rd;
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == (PW+1)'(DEPTH));
  assign empty = (count == '0);
endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the register-file write port between writeback (priority) and buffered
// mdu results, with anti-starvation hold and read-after-write stall for Decode.
module rf_write_arbiter
  import rf_arb_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int AW       = 5,
  parameter int DEPTH    = 4,
  parameter int MAX_WAIT = 8
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     wb_we_i,
  input  logic [AW-1:0]            wb_rd_i,
  input  logic [XLEN-1:0]          wb_data_i,
  input  logic                     mdu_valid_i,
  input  logic [AW-1:0]            mdu_rd_i,
  input  logic [XLEN-1:0]          mdu_data_i,
  output logic                     mdu_ready_o,
  input  logic [AW-1:0]            rs1D_i,
  input  logic [AW-1:0]            rs2D_i,
  output logic                     raw_stall_o,
  output logic                     hold_o,
  output logic                     rf_we_o,
  output logic [AW-1:0]            rf_a3_o,
  output logic [XLEN-1:0]          rf_wd3_o,
  output logic [$clog2(DEPTH):0]   occupancy_o
);
  localparam int AGW = $clog2(MAX_WAIT + 1);

  if (XLEN != RF_XLEN || AW != RF_AW || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || MAX_WAIT < 1)
  begin : g_bad_params
    $error("rf_write_arbiter: unsupported parameter set");
  end

  rf_entry_t                 head;
  logic [DEPTH-1:0]          ent_valid;
  logic [DEPTH-1:0]          ent_kill;
  logic [DEPTH-1:0][AW-1:0]  ent_rd;
  logic [$clog2(DEPTH):0]    count;
  logic                      full;
  logic                      empty;
  logic [AGW-1:0]            age_q;
  logic                      wb_req;
  logic                      force_hold;
  logic                      push;
  gnt_src_t                  gnt;

  assign wb_req      = wb_we_i && (wb_rd_i != ZERO_REG);
  assign force_hold  = !empty && (age_q >= AGW'(MAX_WAIT));
  assign mdu_ready_o = !RST && !full;
  // x0 results complete the handshake but never occupy a slot.
  assign push        = mdu_valid_i && mdu_ready_o && (mdu_rd_i != ZERO_REG);

  always_comb begin
    gnt = GNT_NONE;
    if (force_hold)  gnt = GNT_MDU;
    else if (wb_req) gnt = GNT_WB;
    else if (!empty) gnt = GNT_MDU;
  end

  rf_arb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (CLK),
    .rst       (RST),
    .push      (push),
    .push_rd   (mdu_rd_i),
    .push_data (mdu_data_i),
    .pop       (gnt == GNT_MDU),
    .kill_en   (gnt == GNT_WB),
    .kill_rd   (wb_rd_i),
    .head      (head),
    .ent_valid (ent_valid),
    .ent_kill  (ent_kill),
    .ent_rd    (ent_rd),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      age_q <= '0;
    end else if (empty || gnt == GNT_MDU) begin
      age_q <= '0;
    end else if (age_q < AGW'(MAX_WAIT)) begin
      age_q <= age_q + AGW'(1);
    end
  end

  always_comb begin
    rf_we_o  = 1'b0;
    rf_a3_o  = '0;
    rf_wd3_o = '0;
    if (!RST) begin
      if (gnt == GNT_WB) begin
        rf_we_o  = 1'b1;
        rf_a3_o  = wb_rd_i;
        rf_wd3_o = wb_data_i;
      end else if (gnt == GNT_MDU && head.valid && !head.kill) begin
        rf_we_o  = 1'b1;
        rf_a3_o  = head.rd;
        rf_wd3_o = head.data;
      end
    end
  end

  assign hold_o = !RST && force_hold;

  // Killed entries will never write, so they must not stall Decode.
  always_comb begin
    raw_stall_o = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_valid[i] && !ent_kill[i] &&
          ((rs1D_i != ZERO_REG && ent_rd[i] == rs1D_i) ||
           (rs2D_i != ZERO_REG && ent_rd[i] == rs2D_i)))
        raw_stall_o = 1'b1;
    end
    if (mdu_valid_i &&
        ((rs1D_i != ZERO_REG && mdu_rd_i == rs1D_i) ||
         (rs2D_i != ZERO_REG && mdu_rd_i == rs2D_i)))
      raw_stall_o = 1'b1;
    if (RST) raw_stall_o = 1'b0;
  end

  assign occupancy_o = count;
endmodule

// File: tb/tb_rf_write_arbiter.sv
// Randomized and directed bench for rf_write_arbiter against a queue-based model.
module tb_rf_write_arbiter;
  localparam int XLEN     = 32;
  localparam int AW       = 5;
  localparam int DEPTH    = 4;
  localparam int MAX_WAIT = 8;

  logic            CLK = 1'b0;
  logic            RST = 1'b1;
  logic            wb_we_i = 1'b0;
  logic [AW-1:0]   wb_rd_i = '0;
  logic [XLEN-1:0] wb_data_i = '0;
  logic            mdu_valid_i = 1'b0;
  logic [AW-1:0]   mdu_rd_i = '0;
  logic [XLEN-1:0] mdu_data_i = '0;
  logic            mdu_ready_o;
  logic [AW-1:0]   rs1D_i = '0;
  logic [AW-1:0]   rs2D_i = '0;
  logic            raw_stall_o;
  logic            hold_o;
  logic            rf_we_o;
  logic [AW-1:0]   rf_a3_o;
  logic [XLEN-1:0] rf_wd3_o;
  logic [$clog2(DEPTH):0] occupancy_o;

  rf_write_arbiter #(.XLEN(XLEN), .AW(AW), .DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
    .CLK(CLK), .RST(RST),
    .wb_we_i(wb_we_i), .wb_rd_i(wb_rd_i), .wb_data_i(wb_data_i),
    .mdu_valid_i(mdu_valid_i), .mdu_rd_i(mdu_rd_i), .mdu_data_i(mdu_data_i),
    .mdu_ready_o(mdu_ready_o), .rs1D_i(rs1D_i), .rs2D_i(rs2D_i),
    .raw_stall_o(raw_stall_o), .hold_o(hold_o), .rf_we_o(rf_we_o),
    .rf_a3_o(rf_a3_o), .rf_wd3_o(rf_wd3_o), .occupancy_o(occupancy_o)
  );

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  initial begin
    #1000000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1);
  end

  // ---------------- scoreboard / model ----------------
  typedef struct {
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] data;
    bit              kill;
  } m_ent_t;

  m_ent_t exp_q[$];
  int     age_m = 0;
  int     n_tests = 0;
  int     n_fail = 0;

  logic            obs_we, obs_hold, obs_raw, obs_ready;
  logic [AW-1:0]   obs_a3;
  logic [XLEN-1:0] obs_wd;
  logic [$clog2(DEPTH):0] obs_occ;

  task automatic check_val(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic we, input logic [AW-1:0] wrd, input logic [XLEN-1:0] wd,
                      input logic mv, input logic [AW-1:0] mrd, input logic [XLEN-1:0] md,
                      input logic [AW-1:0] rs1, input logic [AW-1:0] rs2);
    bit frc, wbr, head_gnt, wb_gnt, acc, e_raw, e_we;
    logic [AW-1:0]   e_a3;
    logic [XLEN-1:0] e_wd;
    m_ent_t ne;
    @(negedge CLK);
    wb_we_i = we; wb_rd_i = wrd; wb_data_i = wd;
    mdu_valid_i = mv; mdu_rd_i = mrd; mdu_data_i = md;
    rs1D_i = rs1; rs2D_i = rs2;
    #1;
    frc      = (exp_q.size() > 0) && (age_m >= MAX_WAIT);
    wbr      = we && (wrd != 0);
    wb_gnt   = !frc && wbr;
    head_gnt = frc || (!wbr && exp_q.size() > 0);
    e_we = 1'b0; e_a3 = '0; e_wd = '0;
    if (wb_gnt) begin
      e_we = 1'b1; e_a3 = wrd; e_wd = wd;
    end else if (head_gnt && !exp_q[0].kill) begin
      e_we = 1'b1; e_a3 = exp_q[0].rd; e_wd = exp_q[0].data;
    end
    e_raw = 1'b0;
    foreach (exp_q[i])
      if (!exp_q[i].kill && ((rs1 != 0 && exp_q[i].rd == rs1) || (rs2 != 0 && exp_q[i].rd == rs2)))
        e_raw = 1'b1;
    if (mv && ((rs1 != 0 && mrd == rs1) || (rs2 != 0 && mrd == rs2))) e_raw = 1'b1;

    obs_we = rf_we_o; obs_a3 = rf_a3_o; obs_wd = rf_wd3_o; obs_hold = hold_o;
    obs_raw = raw_stall_o; obs_ready = mdu_ready_o; obs_occ = occupancy_o;
    check_val("we",    32'(obs_we),    32'(e_we));
    check_val("a3",    32'(obs_a3),    32'(e_a3));
    check_val("wd3",   obs_wd,         e_wd);
    check_val("hold",  32'(obs_hold),  32'(frc));
    check_val("raw",   32'(obs_raw),   32'(e_raw));
    check_val("ready", 32'(obs_ready), 32'(exp_q.size() < DEPTH));
    check_val("occ",   32'(obs_occ),   32'(exp_q.size()));

    acc = mv && (exp_q.size() < DEPTH);
    @(posedge CLK);
    if (exp_q.size() == 0 || head_gnt) age_m = 0;
    else if (age_m < MAX_WAIT) age_m++;
    if (wb_gnt) foreach (exp_q[i]) if (exp_q[i].rd == wrd) exp_q[i].kill = 1'b1;
    if (head_gnt) void'(exp_q.pop_front());
    if (acc && mrd != 0) begin
      ne.rd = mrd; ne.data = md; ne.kill = 1'b0;
      exp_q.push_back(ne);
    end
  endtask

  task automatic idle(input logic [AW-1:0] rs1);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, rs1, 5'd0);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    wb_we_i = 1'b1; wb_rd_i = 5'd3; mdu_valid_i = 1'b1; mdu_rd_i = 5'd3; rs1D_i = 5'd3;
    #2 RST = 1'b1;
    #1;
    check_val("rst_we",    32'(rf_we_o),     32'd0);
    check_val("rst_a3",    32'(rf_a3_o),     32'd0);
    check_val("rst_hold",  32'(hold_o),      32'd0);
    check_val("rst_raw",   32'(raw_stall_o), 32'd0);
    check_val("rst_occ",   32'(occupancy_o), 32'd0);
    check_val("rst_ready", 32'(mdu_ready_o), 32'd0);
    exp_q.delete();
    age_m = 0;
    repeat (2) @(negedge CLK);
    wb_we_i = 1'b0; wb_rd_i = '0; wb_data_i = '0;
    mdu_valid_i = 1'b0; mdu_rd_i = '0; mdu_data_i = '0;
    rs1D_i = '0; rs2D_i = '0;
    RST = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  int hold_at;
  logic [AW-1:0]   hold_a3;
  logic [XLEN-1:0] hold_wd;
  int pw, pm;

  initial begin
    #3;
    check_val("init_we",    32'(rf_we_o),     32'd0);
    check_val("init_occ",   32'(occupancy_o), 32'd0);
    check_val("init_ready", 32'(mdu_ready_o), 32'd0);
    @(negedge CLK);
    RST = 1'b0;

    // idle drain
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0);
    idle(5'd0);
    check_val("drain_we", 32'(obs_we), 32'd1);
    check_val("drain_a3", 32'(obs_a3), 32'd5);
    check_val("drain_wd", obs_wd, 32'hDEADBEEF);
    idle(5'd0);
    check_val("drain_occ", 32'(obs_occ), 32'd0);

    // priority
    do_reset();
    step(1'b1, 5'd3, 32'h11, 1'b1, 5'd7, 32'h22, 5'd0, 5'd0);
    repeat (3) begin
      step(1'b1, 5'd3, 32'h11, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
      check_val("prio_wb_a3", 32'(obs_a3), 32'd3);
    end
    idle(5'd0);
    check_val("prio_mdu_a3", 32'(obs_a3), 32'd7);
    check_val("prio_mdu_wd", obs_wd, 32'h22);

    // starvation
    do_reset();
    step(1'b1, 5'd3, 32'h11, 1'b1, 5'd7, 32'h22, 5'd0, 5'd0);
    hold_at = 0; hold_a3 = '0; hold_wd = '0;
    for (int k = 1; k <= 20 && hold_at == 0; k++) begin
      step(1'b1, 5'd3, 32'h11, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
      if (obs_hold) begin hold_at = k; hold_a3 = obs_a3; hold_wd = obs_wd; end
    end
    check_val("starve_cycle", 32'(hold_at), 32'd9);
    check_val("starve_a3", 32'(hold_a3), 32'd7);
    check_val("starve_wd", hold_wd, 32'h22);
    step(1'b1, 5'd3, 32'h11, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    check_val("starve_release", 32'(obs_hold), 32'd0);

    // full
    do_reset();
    for (int i = 0; i < 4; i++)
      step(1'b1, 5'd3, 32'h11, 1'b1, 5'(i + 1), 32'(i + 100), 5'd0, 5'd0);
    step(1'b1, 5'd3, 32'h11, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    check_val("full_ready", 32'(obs_ready), 32'd0);
    check_val("full_occ",   32'(obs_occ),   32'd4);
    idle(5'd0);
    idle(5'd0);
    check_val("full_freed", 32'(obs_ready), 32'd1);

    // RAW and kill
    do_reset();
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h99, 5'd9, 5'd0);
    step(1'b1, 5'd9, 32'h55, 1'b0, 5'd0, 32'd0, 5'd9, 5'd0);
    check_val("raw_pending", 32'(obs_raw), 32'd1);
    idle(5'd9);
    check_val("raw_killed", 32'(obs_raw), 32'd0);
    check_val("kill_nowrite", 32'(obs_we), 32'd0);
    step(1'b1, 5'd0, 32'h77, 1'b1, 5'd0, 32'h88, 5'd0, 5'd0);
    check_val("x0_nowrite", 32'(obs_we), 32'd0);
    check_val("x0_nostall", 32'(obs_raw), 32'd0);
    idle(5'd0);
    check_val("x0_noenq", 32'(obs_occ), 32'd0);

    // mid-operation reset
    do_reset();
    step(1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h44, 5'd0, 5'd0);
    step(1'b1, 5'd3, 32'h11, 1'b1, 5'd5, 32'h45, 5'd0, 5'd0);
    step(1'b1, 5'd3, 32'h11, 1'b1, 5'd6, 32'h46, 5'd0, 5'd0);
    repeat (3) step(1'b1, 5'd3, 32'h11, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    do_reset();
    repeat (3) begin
      idle(5'd4);
      check_val("post_rst_we", 32'(obs_we), 32'd0);
    end

    // randomized phases
    for (int ph = 0; ph < 30; ph++) begin
      pw = $urandom_range(0, 100);
      pm = $urandom_range(0, 100);
      for (int k = 0; k < 100; k++) begin
        if ($urandom_range(0, 299) == 0) do_reset();
        step(($urandom_range(0, 99) < pw), 5'($urandom_range(0, 7)), $urandom,
             ($urandom_range(0, 99) < pm), 5'($urandom_range(0, 7)), $urandom,
             5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
- Shares the register file's single write port (A3/WD3/WE3) between two requesters: the pipeline writeback stage and a long-latency result source (multiply/divide unit, "mdu").
- The writeback stage has priority. mdu results are buffered in a small FIFO and drained on cycles when writeback does not use the port.
- The block also raises a read-after-write stall toward Decode for operands still waiting in the buffer, and an anti-starvation hold toward the pipeline.
- It sits between the W stage, the mdu and the register file write port.

Parameters:
- XLEN, 32, data width
- AW, 5, register address width
- DEPTH, 4, FIFO entries; power of two, at least 2
- MAX_WAIT, 8, cycles the FIFO head may be denied before hold is forced; at least 1

Ports:
- CLK  in  1  clock; all state updates on the rising edge
- RST  in  1  reset; asynchronous, active-high
- wb_we_i  in  1  writeback requests a register write
- wb_rd_i  in  AW  writeback destination
- wb_data_i  in  XLEN  writeback data
- mdu_valid_i  in  1  mdu result valid
- mdu_rd_i  in  AW  mdu destination
- mdu_data_i  in  XLEN  mdu result
- mdu_ready_o  out  1  FIFO can accept a result
- rs1D_i  in  AW  Decode source 1
- rs2D_i  in  AW  Decode source 2
- raw_stall_o  out  1  Decode must stall (pending write to a source register)
- hold_o  out  1  freeze the pipeline including W; the writeback request is re-presented next cycle
- rf_we_o  out  1  register file write enable
- rf_a3_o  out  AW  register file write address
- rf_wd3_o  out  XLEN  register file write data
- occupancy_o  out  clog2(DEPTH)+1  valid FIFO entries

Behaviour:
- **Reset:** RST asserted (asynchronous) empties the FIFO, clears age_q and all kill bits, and forces occupancy_o=0 and mdu_ready_o=0. While RST is asserted, raw_stall_o, hold_o and rf_we_o are 0. Asserting RST mid-operation discards queued results silently. mdu_ready_o rises in the first cycle after RST deasserts.
- **Request qualification:**
  - wb_req = wb_we_i and wb_rd_i != 0.
  - An mdu result with mdu_rd_i == 0 is accepted (handshake completes) but not enqueued.
- **Enqueue:** occurs when mdu_valid_i and mdu_ready_o at the clock edge.
  - mdu_ready_o = not full, computed from registered count only; there is no same-cycle pass-through when full.
  - Earliest register-file write of an mdu result is the cycle after acceptance (latency 1; no bypass).
- **Grant (combinational from registered state plus inputs):**
  - force = FIFO non-empty and age_q >= MAX_WAIT.
  - If force: hold_o=1, grant the FIFO head, suppress the writeback write.
  - Else if wb_req: grant writeback (rf_* = wb_*).
  - Else if FIFO non-empty: grant the head.
  - Else: rf_we_o=0, with rf_a3_o and rf_wd3_o set to 0.
- **Head dequeue:** the head is dequeued on the edge at which it is granted.
  - A killed head is dequeued with rf_we_o=0. This counts as a grant and takes no port.
- **Aging:**
  - age_q increments each cycle the FIFO is non-empty and the head is not granted, saturating at MAX_WAIT.
  - age_q clears on a head grant or when the FIFO is empty.
- **Write-after-write kill:** writeback is always younger than queued mdu results.
  - When writeback is granted with rd=R, every valid FIFO entry with rd=R gets its kill bit set at that edge.
  - An mdu result enqueued in the same cycle is not killed.
- **Simultaneous enqueue and dequeue:** count is unchanged; the pointers wrap modulo DEPTH.
- **raw_stall_o:** 1 when rsX_i != 0 matches the rd of any valid, non-killed FIFO entry, or matches mdu_rd_i while mdu_valid_i is 1.
- **occupancy_o:** the registered count, including killed entries not yet dequeued.

Decomposition:
- **Shared package** rf_arb_pkg: the FIFO entry struct {valid, kill, rd[AW], data[XLEN]}, the grant-source enum {GNT_NONE, GNT_WB, GNT_MDU}, and a ZERO_REG constant.
- **One sub-module**, rf_arb_fifo: storage, pointers and kill bits, exposing the head entry, per-entry rd/valid vectors for RAW compare, and a kill_rd strobe.
- **Top level** holds grant logic, aging and the RAW compare.

Test Plan:
1. **Idle drain:** mdu result x5=0xDEADBEEF with no writeback → next cycle rf_we_o=1, rf_a3_o=5, rf_wd3_o=0xDEADBEEF; occupancy_o returns to 0.
2. **Priority:** wb x3=0x11 held every cycle and mdu x7=0x22 accepted → port shows x3 writes; x7 written on the first cycle wb_we_i=0.
3. **Starvation:** wb_req continuous, one queued entry, MAX_WAIT=8 → hold_o=1 exactly on the 9th cycle after enqueue; x7 written that cycle; hold_o=0 the next cycle.
4. **Full:** four mdu results with wb busy → mdu_ready_o=0 and occupancy_o=4. One drain frees one slot; mdu_ready_o=1 the next cycle.
5. **RAW and kill:** queued x9, rs1D_i=9 → raw_stall_o=1. A wb write to x9 kills the entry: raw_stall_o=0, and the later dequeue shows rf_we_o=0. x0 requests never write and never stall.
6. **Mid-operation reset:** assert RST with 3 entries and age_q=5 → outputs 0 immediately, occupancy_o=0, with no stale writes after release.
